uart_tx_arbiter: RTL

- Shares the single UART transmit path (w_data / wr_uart / tx_full) between NREQ independent requesters.
- Grants are whole packets: once a requester wins, its bytes go out back-to-back until it marks the last byte.
- Round-robin arbitration between packets; a length guard stops one requester from holding the link indefinitely.
- Sits between on-chip message sources (debug, status, CPU mailbox) and the UART TX FIFO.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_MAX_LEN = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    pos;
  logic [IDW:0]      idx_sum;

  // Rotate so ptr lands at bit 0, then the lowest set bit is the winner.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NREQ-1:0];
  assign any = |req;

  always_comb begin
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) pos = IDW'(k);
    end
  end

  always_comb begin
    idx_sum = {1'b0, ptr} + {1'b0, pos};
    if (idx_sum >= (IDW + 1)'(NREQ)) idx_sum = idx_sum - (IDW + 1)'(NREQ);
    idx = idx_sum[IDW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port
// between NREQ byte sources, with a per-grant length guard.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DBIT    = DEF_DBIT,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int IDW     = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [DBIT-1:0]      w_data,
  output logic                 wr_uart,
  input  logic                 tx_full,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 trunc_err
);

  localparam int            CW       = clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

  arb_state_t      state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt, pick_idx;
  logic            pick_any;
  logic [CW-1:0]   byte_cnt;
  logic            owner_valid, owner_last, accept, at_limit, release_pkt;
  logic [DBIT-1:0] owner_data;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_valid = req_valid[grant_id];
  assign owner_last  = req_last[grant_id];
  assign owner_data  = req_data[grant_id*DBIT +: DBIT];
  assign accept      = (state == GRANT) & owner_valid & ~tx_full;
  assign at_limit    = (byte_cnt == LAST_CNT);
  assign release_pkt = accept & (owner_last | at_limit);
  assign ptr_nxt     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = GRANT;
      GRANT:   if (release_pkt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    wr_uart   = 1'b0;
    w_data    = '0;
    busy      = 1'b0;
    if (state == GRANT) begin
      busy                = 1'b1;
      req_ready[grant_id] = ~tx_full;
      wr_uart             = owner_valid & ~tx_full;
      w_data              = owner_data;
    end
  end

  // The owner index survives the return to IDLE; only a new grant replaces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      grant_id  <= '0;
      byte_cnt  <= '0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= release_pkt & ~owner_last;
      if (state == IDLE && pick_any) begin
        grant_id <= pick_idx;
        byte_cnt <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (release_pkt) ptr <= ptr_nxt;
      end
    end
  end

endmodule
